// File: rtl/traffic_light_pkg.sv
// Shared types for the two-head traffic light monitor: head FSM states,
// error bit positions and the {red, yellow, green} lamp vector.
package traffic_light_pkg;

   typedef enum logic [1:0] {
      ST_UNSYNC = 2'd0,
      ST_GREEN  = 2'd1,
      ST_YELLOW = 2'd2,
      ST_RED    = 2'd3
   } head_state_t;

   localparam int ERR_ONEHOT   = 0;
   localparam int ERR_CONFLICT = 1;
   localparam int ERR_SEQ      = 2;
   localparam int ERR_TIMING   = 3;
   localparam int ERR_STUCK    = 4;
   localparam int ERR_W        = 5;

   typedef struct packed {
      logic red;
      logic yellow;
      logic green;
   } lamp_t;

   localparam lamp_t LAMP_RED    = 3'b100;
   localparam lamp_t LAMP_YELLOW = 3'b010;
   localparam lamp_t LAMP_GREEN  = 3'b001;

   function automatic logic lamp_is_go(lamp_t l);
      return l.green | l.yellow;
   endfunction

endpackage

// File: rtl/traffic_head_checker.sv
// Per-head lamp tracker: samples one head, follows its phase FSM and flags
// ONEHOT/SEQ/TIMING (and STUCK when TL_MON_STUCK_EN is defined).
module traffic_head_checker
   import traffic_light_pkg::*;
#(
   parameter int GREEN_CYCLES  = 16000000,
   parameter int YELLOW_CYCLES = 3200000,
   parameter int DUR_W         = 32,
   parameter int STUCK_CYCLES  = 64000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       lamps,
   output logic [ERR_W-1:0] err,
   output logic             synced,
   output logic             enter_green,
   output logic [2:0]       samp,
   output logic             samp_vld
);

   localparam logic [DUR_W-1:0] GREEN_DUR  = DUR_W'(GREEN_CYCLES);
   localparam logic [DUR_W-1:0] YELLOW_DUR = DUR_W'(YELLOW_CYCLES);
   localparam logic [DUR_W-1:0] RED_DUR    = DUR_W'(GREEN_CYCLES + YELLOW_CYCLES);

   lamp_t            samp_q;
   lamp_t            prev_q;
   logic             prev_vld;
   head_state_t      state;
   head_state_t      state_nxt;
   logic [DUR_W-1:0] dur;
   logic [DUR_W-1:0] dur_nxt;
   logic             restart;
   logic             changed;
   logic             dur_sat;

   assign samp    = samp_q;
   assign synced  = (state != ST_UNSYNC);
   assign changed = prev_vld && (samp_q != prev_q);
   assign restart = !prev_vld || changed;
   assign dur_sat = (dur == '1);

`ifdef TL_MON_STUCK_EN
   localparam logic [DUR_W-1:0] STUCK_DUR = DUR_W'(STUCK_CYCLES);
   logic stuck_hit;
   assign stuck_hit = samp_vld && (dur_nxt == STUCK_DUR) && (dur != STUCK_DUR);
`else
   logic unused_stuck;
   assign unused_stuck = (STUCK_CYCLES != 0);
`endif

   // A saturated count never matches a phase length, so dur_sat forces TIMING.
   always_comb begin
      state_nxt   = state;
      err         = '0;
      enter_green = 1'b0;
      if (restart)
         dur_nxt = DUR_W'(1);
      else if (dur_sat)
         dur_nxt = dur;
      else
         dur_nxt = dur + DUR_W'(1);

      if (samp_vld) begin
         if (!$onehot(samp_q)) begin
            err[ERR_ONEHOT] = 1'b1;
            state_nxt       = ST_UNSYNC;
         end else if (changed) begin
            case (state)
               ST_UNSYNC: begin
                  if (prev_q == LAMP_RED && samp_q == LAMP_GREEN) begin
                     state_nxt   = ST_GREEN;
                     enter_green = 1'b1;
                  end
               end
               ST_GREEN: begin
                  if (samp_q == LAMP_YELLOW) begin
                     state_nxt       = ST_YELLOW;
                     err[ERR_TIMING] = dur_sat || (dur != GREEN_DUR);
                  end else begin
                     state_nxt    = ST_UNSYNC;
                     err[ERR_SEQ] = 1'b1;
                  end
               end
               ST_YELLOW: begin
                  if (samp_q == LAMP_RED) begin
                     state_nxt       = ST_RED;
                     err[ERR_TIMING] = dur_sat || (dur != YELLOW_DUR);
                  end else begin
                     state_nxt    = ST_UNSYNC;
                     err[ERR_SEQ] = 1'b1;
                  end
               end
               ST_RED: begin
                  if (samp_q == LAMP_GREEN) begin
                     state_nxt       = ST_GREEN;
                     enter_green     = 1'b1;
                     err[ERR_TIMING] = dur_sat || (dur != RED_DUR);
                  end else begin
                     state_nxt    = ST_UNSYNC;
                     err[ERR_SEQ] = 1'b1;
                  end
               end
               default: state_nxt = ST_UNSYNC;
            endcase
         end
`ifdef TL_MON_STUCK_EN
         err[ERR_STUCK] = stuck_hit;
`endif
      end
   end

   // The valid bits keep the zeroed reset samples from being judged as lamps.
   always_ff @(posedge clk) begin
      if (rst) begin
         samp_q   <= '0;
         prev_q   <= '0;
         samp_vld <= 1'b0;
         prev_vld <= 1'b0;
         state    <= ST_UNSYNC;
         dur      <= '0;
      end else begin
         samp_q   <= lamp_t'(lamps);
         prev_q   <= samp_q;
         samp_vld <= 1'b1;
         prev_vld <= samp_vld;
         if (samp_vld) begin
            state <= state_nxt;
            dur   <= dur_nxt;
         end
      end
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive two-head lamp monitor: cross-head conflict check, sticky/pulse error
// aggregation and completed-cycle count. Optional watchdog: TL_MON_STUCK_EN.
module traffic_light_monitor
   import traffic_light_pkg::*;
#(
   parameter int GREEN_CYCLES  = 16000000,
   parameter int YELLOW_CYCLES = 3200000,
   parameter int DUR_W         = 32,
   parameter int STUCK_CYCLES  = 64000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        red1,
   input  logic        yellow1,
   input  logic        green1,
   input  logic        red2,
   input  logic        yellow2,
   input  logic        green2,
   input  logic        clr_err,
   output logic [4:0]  err_sticky,
   output logic        err_pulse,
   output logic        synced,
   output logic [15:0] cycles_done
);

   logic [ERR_W-1:0] err1;
   logic [ERR_W-1:0] err2;
   logic [ERR_W-1:0] new_err;
   logic             synced1;
   logic             synced2;
   logic             enter_green1;
   logic             unused_enter_green2;
   logic [2:0]       samp1;
   logic [2:0]       samp2;
   logic             vld1;
   logic             vld2;

   traffic_head_checker #(
      .GREEN_CYCLES (GREEN_CYCLES),
      .YELLOW_CYCLES(YELLOW_CYCLES),
      .DUR_W        (DUR_W),
      .STUCK_CYCLES (STUCK_CYCLES)
   ) u_head1 (
      .clk        (clk),
      .rst        (rst),
      .lamps      ({red1, yellow1, green1}),
      .err        (err1),
      .synced     (synced1),
      .enter_green(enter_green1),
      .samp       (samp1),
      .samp_vld   (vld1)
   );

   traffic_head_checker #(
      .GREEN_CYCLES (GREEN_CYCLES),
      .YELLOW_CYCLES(YELLOW_CYCLES),
      .DUR_W        (DUR_W),
      .STUCK_CYCLES (STUCK_CYCLES)
   ) u_head2 (
      .clk        (clk),
      .rst        (rst),
      .lamps      ({red2, yellow2, green2}),
      .err        (err2),
      .synced     (synced2),
      .enter_green(unused_enter_green2),
      .samp       (samp2),
      .samp_vld   (vld2)
   );

   assign synced = synced1 & synced2;

   always_comb begin
      new_err               = err1 | err2;
      new_err[ERR_CONFLICT] = vld1 && vld2 && lamp_is_go(lamp_t'(samp1))
                              && lamp_is_go(lamp_t'(samp2));
   end

   // A violation coinciding with clr_err still lands, since it is OR-ed after the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_sticky  <= '0;
         err_pulse   <= 1'b0;
         cycles_done <= '0;
      end else begin
         err_sticky <= (clr_err ? '0 : err_sticky) | new_err;
         err_pulse  <= |new_err;
         if (enter_green1 && synced1 && cycles_done != 16'hFFFF)
            cycles_done <= cycles_done + 16'd1;
      end
   end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed scoreboard bench for traffic_light_monitor with 30/5-cycle phases;
// expectations are queued when lamps are driven and compared when they fall due.
module tb_traffic_light_monitor;

   localparam int F_STICKY = 0;
   localparam int F_PULSE  = 1;
   localparam int F_SYNCED = 2;
   localparam int F_CYCLES = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        red1 = 1'b0, yellow1 = 1'b0, green1 = 1'b0;
   logic        red2 = 1'b0, yellow2 = 1'b0, green2 = 1'b0;
   logic        clr_err = 1'b0;
   logic [4:0]  err_sticky;
   logic        err_pulse;
   logic        synced;
   logic [15:0] cycles_done;

   typedef struct {
      int          due;
      int          field;
      logic [15:0] exp;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   t        = 0;
   int   g1_len   = 30;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   traffic_light_monitor #(
      .GREEN_CYCLES (30),
      .YELLOW_CYCLES(5),
      .DUR_W        (32),
      .STUCK_CYCLES (1000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .red1       (red1),
      .yellow1    (yellow1),
      .green1     (green1),
      .red2       (red2),
      .yellow2    (yellow2),
      .green2     (green2),
      .clr_err    (clr_err),
      .err_sticky (err_sticky),
      .err_pulse  (err_pulse),
      .synced     (synced),
      .cycles_done(cycles_done)
   );

   function automatic logic [15:0] observe(int field);
      case (field)
         F_STICKY: return {11'b0, err_sticky};
         F_PULSE:  return {15'b0, err_pulse};
         F_SYNCED: return {15'b0, synced};
         default:  return cycles_done;
      endcase
   endfunction

   // {red, yellow, green} for a head at phase ph of a 70-cycle period.
   function automatic logic [2:0] head_lamp(int ph, int glen);
      if (ph < glen)          return 3'b001;
      else if (ph < glen + 5) return 3'b010;
      else                    return 3'b100;
   endfunction

   task automatic expectIn(int delay, int field, logic [15:0] val, string tag);
      exp_t e;
      e.due   = cyc + delay;
      e.field = field;
      e.exp   = val;
      e.tag   = tag;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      logic [15:0] obs;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            obs = observe(sb[i].field);
            checks++;
            assert (obs === sb[i].exp) else begin
               failures++;
               $error("[TB] FAIL %s: observed=%0h expected=%0h", sb[i].tag, obs, sb[i].exp);
            end
            sb.delete(i);
         end
      end
   endtask

   task automatic applyStimulus(logic [2:0] l1, logic [2:0] l2, logic clr, logic rst_v);
      @(negedge clk);
      cyc++;
      checkOutput();
      {red1, yellow1, green1} = l1;
      {red2, yellow2, green2} = l2;
      clr_err = clr;
      rst     = rst_v;
   endtask

   task automatic patternStep(logic use1, logic [2:0] ovr1, logic clr);
      logic [2:0] l1;
      l1 = use1 ? ovr1 : head_lamp((t + 35) % 70, g1_len);
      applyStimulus(l1, head_lamp(t % 70, 30), clr, 1'b0);
      t++;
   endtask

   task automatic runTo(int t_end);
      while (t < t_end) patternStep(1'b0, 3'b000, 1'b0);
   endtask

   task automatic resetDut();
      repeat (3) applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
      t      = 0;
      g1_len = 30;
   endtask

   initial begin
      $display("[TB] start");

      // Reset with arbitrary lamps, then the ideal two-head pattern.
      resetDut();
      patternStep(1'b0, 3'b000, 1'b0);
      expectIn(1, F_STICKY, 16'h0, "rst_sticky");
      expectIn(1, F_PULSE,  16'h0, "rst_pulse");
      expectIn(1, F_SYNCED, 16'h0, "rst_synced");
      expectIn(1, F_CYCLES, 16'h0, "rst_cycles");
      runTo(70);
      patternStep(1'b0, 3'b000, 1'b0);
      expectIn(1, F_SYNCED, 16'h0, "sync_before_h2");
      expectIn(2, F_SYNCED, 16'h1, "sync_after_h2");
      runTo(105);
      patternStep(1'b0, 3'b000, 1'b0);
      expectIn(1, F_CYCLES, 16'h0, "cycles_before_first");
      expectIn(2, F_CYCLES, 16'h1, "cycles_first");
      runTo(320);
      expectIn(2, F_CYCLES, 16'h4, "cycles_four");
      expectIn(2, F_STICKY, 16'h0, "ideal_sticky");

      // Head 1 green held one cycle short.
      runTo(385);
      g1_len = 29;
      patternStep(1'b0, 3'b000, 1'b0);
      expectIn(2, F_CYCLES, 16'h5, "cycles_five");
      runTo(414);
      patternStep(1'b0, 3'b000, 1'b0);
      expectIn(1, F_PULSE,  16'h0,  "timing_pulse_early");
      expectIn(2, F_PULSE,  16'h1,  "timing_pulse");
      expectIn(2, F_STICKY, 16'h08, "timing_sticky");
      expectIn(3, F_PULSE,  16'h0,  "timing_pulse_single");
      expectIn(3, F_SYNCED, 16'h1,  "timing_keeps_sync");
      runTo(419);

      // Both heads green in the first sample after reset.
      resetDut();
      patternStep(1'b1, 3'b001, 1'b0);
      expectIn(2, F_STICKY, 16'h02, "conflict_sticky");
      expectIn(2, F_PULSE,  16'h1,  "conflict_pulse");
      expectIn(3, F_PULSE,  16'h0,  "conflict_pulse_single");
      expectIn(3, F_STICKY, 16'h02, "conflict_sticky_hold");
      runTo(5);

      // Red and green lit together on head 1 while synced.
      resetDut();
      runTo(110);
      expectIn(1, F_SYNCED, 16'h1, "pre_onehot_sync");
      patternStep(1'b1, 3'b101, 1'b0);
      expectIn(2, F_STICKY, 16'h01, "onehot_sticky");
      expectIn(2, F_PULSE,  16'h1,  "onehot_pulse");
      expectIn(2, F_SYNCED, 16'h0,  "onehot_desync");
      runTo(175);
      patternStep(1'b0, 3'b000, 1'b0);
      expectIn(1, F_SYNCED, 16'h0,  "resync_before");
      expectIn(2, F_SYNCED, 16'h1,  "resync_after");
      expectIn(2, F_CYCLES, 16'h1,  "resync_no_count");
      expectIn(2, F_STICKY, 16'h01, "onehot_sticky_hold");

      // Head 1 green straight to red, with clr_err on the flag-update edge.
      runTo(190);
      patternStep(1'b1, 3'b100, 1'b0);
      patternStep(1'b1, 3'b100, 1'b1);
      expectIn(1, F_STICKY, 16'h04, "seq_beats_clear");
      expectIn(1, F_PULSE,  16'h1,  "seq_pulse");
      patternStep(1'b1, 3'b100, 1'b0);
      expectIn(1, F_SYNCED, 16'h0,  "seq_desync");
      while (t < 200) patternStep(1'b1, 3'b100, 1'b0);
      patternStep(1'b1, 3'b100, 1'b1);
      expectIn(1, F_STICKY, 16'h0, "clear_sticky");
      expectIn(1, F_PULSE,  16'h0, "clear_no_pulse");
      repeat (3) patternStep(1'b1, 3'b100, 1'b0);

      foreach (sb[i]) begin
         checks++;
         failures++;
         $error("[TB] FAIL %s: observed=never expected=%0h", sb[i].tag, sb[i].exp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
